// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight,
// and buffers returned words with their PC for decode.
module ifetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  state_t           state_p0, state_d;
  logic [31:0]      fetch_pc_p0, fetch_pc_d;
  logic [CNT_W-1:0] count_p1, count_d, count_step;
  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [31:0]      buf_inst_p1 [BUF_DEPTH];
  logic [31:0]      buf_pc_p1   [BUF_DEPTH];

  logic buf_empty, buf_full, accept, pop, push, rsp_in_wait, req_outstanding;

  assign buf_empty = (count_p1 == '0);
  assign buf_full  = (count_p1 == FULL_CNT);

  assign imem_req_valid = !reset && (state_p0 == S_REQ) && !buf_full;
  assign imem_req_addr  = fetch_pc_p0;
  assign accept         = imem_req_valid && imem_req_ready;

  assign inst_valid  = !reset && !buf_empty;
  assign pop         = inst_valid && inst_ready;
  assign rsp_in_wait = (state_p0 == S_WAIT) && imem_rsp_valid;
  assign push        = rsp_in_wait && !redirect_valid;

  // A response arriving alongside the redirect retires the old request, so
  // only a request still unanswered after this cycle needs a drop state.
  assign req_outstanding = accept ||
                           (((state_p0 == S_WAIT) || (state_p0 == S_DROP)) && !imem_rsp_valid);

  assign instruction = buf_empty ? 32'h0 : buf_inst_p1[rd_ptr_p1];
  assign inst_pc     = buf_empty ? 32'h0 : buf_pc_p1[rd_ptr_p1];
  assign opcode      = instruction[6:0];

  always_comb begin
    count_step = count_p1;
    if (push && !pop)      count_step = count_p1 + CNT_ONE;
    else if (pop && !push) count_step = count_p1 - CNT_ONE;
  end

  always_comb begin
    state_d    = state_p0;
    fetch_pc_d = fetch_pc_p0;
    count_d    = count_step;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      count_d    = '0;
      state_d    = req_outstanding ? S_DROP : S_REQ;
    end else begin
      unique case (state_p0)
        S_REQ: begin
          if (accept) begin
            fetch_pc_d = fetch_pc_p0 + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) state_d = (count_step == FULL_CNT) ? S_FULL : S_REQ;
        end
        S_FULL: begin
          if (count_step != FULL_CNT) state_d = S_REQ;
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // fetch control (p0) and buffer occupancy (p1) registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= S_REQ;
      fetch_pc_p0 <= PC_RESET;
      count_p1    <= '0;
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
    end else begin
      state_p0    <= state_d;
      fetch_pc_p0 <= fetch_pc_d;
      count_p1    <= count_d;
      if (redirect_valid) begin
        wr_ptr_p1 <= '0;
        rd_ptr_p1 <= '0;
      end else begin
        if (push) wr_ptr_p1 <= wr_ptr_p1 + PTR_ONE;
        if (pop)  rd_ptr_p1 <= rd_ptr_p1 + PTR_ONE;
      end
    end
  end

  // buffer storage (p1); fetch_pc already points past the word being returned
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst_p1[wr_ptr_p1] <= imem_rsp_data;
      buf_pc_p1[wr_ptr_p1]   <= fetch_pc_p0 - 32'd4;
    end
  end

endmodule
